rename_pipe_stage: RTL and testbench
====================================

Name: rename_pipe_stage

Overview:
- Next-generation rename stage: the RAT, free list and PRN ready table are internal, replacing the external renamer.
- Adds valid/ready handshakes on both sides, stalls on free-list exhaustion, tracks wakeups while the output is held, and recovers in one cycle on flush from a committed RAT.
- Sits between fetch/decode and issue/ROB.

Parameters:
- ARN_BITS, 5: architectural register index width; NUM_ARCH = 2^ARN_BITS.
- PRN_BITS, 6: physical register index width; NUM_PHYS = 2^PRN_BITS; PRN_BITS > ARN_BITS is required.
- MAX_OPERANDS, 3: source slots and destination slots per instruction.
- FU_COUNT, 4: functional unit count; FUC_BITS = $clog2(FU_COUNT).
- INST_ID_BITS, 6: ROB instruction ID width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage accepts this cycle
- in_inst_id  in  INST_ID_BITS  ROB ID
- in_raw_instr  in  32  passthrough
- in_instr_pc  in  64  passthrough
- in_fu_choice  in  FUC_BITS  passthrough
- in_src_valid[MAX_OPERANDS]  in  1  source slot used
- in_src_arn[MAX_OPERANDS]  in  ARN_BITS  source ARN
- in_dst_valid[MAX_OPERANDS]  in  1  destination slot used
- in_dst_arn[MAX_OPERANDS]  in  ARN_BITS  destination ARN
- out_valid  out  1  renamed instruction valid
- out_ready  in  1  downstream accepts
- out_inst_id, out_raw_instr, out_instr_pc, out_fu_choice  out  as inputs  registered passthrough
- out_src_valid/out_src_ready/out_src_prn[MAX_OPERANDS]  out  1/1/PRN_BITS  renamed sources
- out_dst_valid/out_dst_prn/out_old_prn/out_dst_arn[MAX_OPERANDS]  out  1/PRN_BITS/PRN_BITS/ARN_BITS  new PRN, overwritten PRN, and ARN for the ROB
- wb_valid/wb_prn[MAX_OPERANDS]  in  1/PRN_BITS  writeback wakeups
- free_valid/free_prn[MAX_OPERANDS]  in  1/PRN_BITS  PRNs returned at commit
- commit_valid/commit_arn/commit_prn[MAX_OPERANDS]  in  1/ARN_BITS/PRN_BITS  committed mapping updates
- flush  in  1  squash all speculative state
- free_count  out  PRN_BITS+1  current free-list occupancy

Behaviour:
- Reset:
  - RAT[a]=a and committed RAT[a]=a.
  - Free list holds NUM_ARCH..NUM_PHYS-1 in order; head = committed head = 0; count = NUM_PHYS-NUM_ARCH.
  - All ready bits are 1.
  - Every output register is 0; out_valid=0.
- Handshake:
  - in_ready = !flush && (!out_valid || out_ready) && free_count >= number of set in_dst_valid.
  - in_ready is combinational and has no dependence on in_valid.
  - Fire = in_valid && in_ready. Latency is 1 cycle.
  - The output holds stable while out_valid && !out_ready.
- On fire:
  - Sources read the RAT state from before this instruction's own writes.
  - Destinations pop the free list in slot order, ascending index.
  - out_old_prn = prior RAT[arn].
  - RAT is updated; on duplicate destination ARNs the higher slot wins, and its old_prn is the lower slot's new PRN.
  - Allocated ready bits are cleared.
- Source ready:
  - out_src_ready = ready[prn] OR a same-cycle wb_prn match.
  - While held, a wb hit on out_src_prn sets out_src_ready.
  - Wakeup is applied before allocation clear. No same-cycle conflict is possible.
- Free list:
  - Circular buffer of NUM_PHYS entries.
  - Pushes from free_valid go in slot order, up to MAX_OPERANDS per cycle.
  - Pops and pushes in the same cycle are both applied.
  - Count never exceeds NUM_PHYS-NUM_ARCH; overflow is an assertion failure.
- Commit:
  - Each commit_valid slot writes the committed RAT.
  - Each commit_valid slot advances the committed head by 1, since allocation is in order.
- Flush (wins over fire, same cycle):
  - RAT <= committed RAT including same-cycle commits.
  - head <= committed head including same-cycle commits.
  - Count is recomputed; out_valid <= 0; ready table untouched.
- rst mid-operation: full reinitialisation as at reset.

Optional Feature:
- RENAME_STALL_CNT_EN:
  - Adds outputs stall_freelist_cnt and stall_backpressure_cnt, each 32 bits, saturating.
  - stall_freelist_cnt increments when in_valid && !flush and the free-list check fails.
  - stall_backpressure_cnt increments when in_valid && out_valid && !out_ready.
  - Both clear on rst.
  - Without the macro: neither port nor counter exists.

Test Plan:
- Reset, then one instruction with src X1 and dst X2 -> out_src_prn=1, out_src_ready=1, out_dst_prn=32, out_old_prn=2; next instruction with src X2 -> prn 32, ready=0.
- Hold out_ready=0; wb_prn=32 arrives -> held out_src_ready rises to 1; in_ready stays 0 while out_ready=0.
- Allocate until free_count=1; then an instruction with 2 destinations -> in_ready=0; a free_valid push raises in_ready the next cycle.
- Rename X2 to 32 then 33; commit X2->32; flush -> RAT[2]=32, free_count=31, out_valid=0; next allocation returns 33.
- Duplicate destination X5 in slots 0 and 1 -> slot0 prn 32/old 5, slot1 prn 33/old 32; RAT[5]=33.
- With RENAME_STALL_CNT_EN: 4 cycles of backpressure -> stall_backpressure_cnt=4.

Source files
------------

// File: rtl/rename_pipe_stage.sv
// rename_pipe_stage
// Register rename stage with an internal RAT, committed RAT, circular free
// list and PRN ready table. Accepts one decoded instruction per cycle over a
// valid/ready handshake and presents the renamed instruction one cycle later
// in an output register that holds while downstream back-pressures.
//
// Optional build macro: RENAME_STALL_CNT_EN adds two saturating 32-bit stall
// counters (stall_freelist_cnt, stall_backpressure_cnt).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      upstream handshake (in_ready is combinational)
//   in_inst_id, in_raw_instr, in_instr_pc, in_fu_choice   passthrough fields
//   in_src_valid/in_src_arn  source slots
//   in_dst_valid/in_dst_arn  destination slots
//   out_valid / out_ready    downstream handshake
//   out_*                    registered renamed instruction
//   wb_valid/wb_prn          writeback wakeups
//   free_valid/free_prn      PRNs returned to the free list at commit
//   commit_valid/commit_arn/commit_prn   committed mapping updates
//   flush                    restore speculative state from the committed RAT
//   free_count               free-list occupancy
// PRN_BITS must be greater than ARN_BITS.

module rename_pipe_stage #(
    parameter int ARN_BITS     = 5,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int FU_COUNT     = 4,
    parameter int INST_ID_BITS = 6,
    parameter int FUC_BITS     = $clog2(FU_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INST_ID_BITS-1:0] in_inst_id,
    input  logic [31:0]             in_raw_instr,
    input  logic [63:0]             in_instr_pc,
    input  logic [FUC_BITS-1:0]     in_fu_choice,
    input  logic                    in_src_valid [MAX_OPERANDS],
    input  logic [ARN_BITS-1:0]     in_src_arn   [MAX_OPERANDS],
    input  logic                    in_dst_valid [MAX_OPERANDS],
    input  logic [ARN_BITS-1:0]     in_dst_arn   [MAX_OPERANDS],

    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INST_ID_BITS-1:0] out_inst_id,
    output logic [31:0]             out_raw_instr,
    output logic [63:0]             out_instr_pc,
    output logic [FUC_BITS-1:0]     out_fu_choice,
    output logic                    out_src_valid [MAX_OPERANDS],
    output logic                    out_src_ready [MAX_OPERANDS],
    output logic [PRN_BITS-1:0]     out_src_prn   [MAX_OPERANDS],
    output logic                    out_dst_valid [MAX_OPERANDS],
    output logic [PRN_BITS-1:0]     out_dst_prn   [MAX_OPERANDS],
    output logic [PRN_BITS-1:0]     out_old_prn   [MAX_OPERANDS],
    output logic [ARN_BITS-1:0]     out_dst_arn   [MAX_OPERANDS],

    input  logic                    wb_valid     [MAX_OPERANDS],
    input  logic [PRN_BITS-1:0]     wb_prn       [MAX_OPERANDS],
    input  logic                    free_valid   [MAX_OPERANDS],
    input  logic [PRN_BITS-1:0]     free_prn     [MAX_OPERANDS],
    input  logic                    commit_valid [MAX_OPERANDS],
    input  logic [ARN_BITS-1:0]     commit_arn   [MAX_OPERANDS],
    input  logic [PRN_BITS-1:0]     commit_prn   [MAX_OPERANDS],
    input  logic                    flush,

    output logic [PRN_BITS:0]       free_count
`ifdef RENAME_STALL_CNT_EN
    ,
    output logic [31:0]             stall_freelist_cnt,
    output logic [31:0]             stall_backpressure_cnt
`endif
);

    localparam int NUM_ARCH = 1 << ARN_BITS;
    localparam int NUM_PHYS = 1 << PRN_BITS;
    localparam int FREE_MAX = NUM_PHYS - NUM_ARCH;
    localparam int CNT_BITS = PRN_BITS + 1;
    localparam logic [CNT_BITS-1:0] CNT_ONE = 1;
    localparam logic [PRN_BITS-1:0] PTR_ONE = 1;

    if (PRN_BITS <= ARN_BITS) begin : g_bad_params
        $error("rename_pipe_stage: PRN_BITS must exceed ARN_BITS");
    end

    logic [PRN_BITS-1:0] rat  [NUM_ARCH];
    logic [PRN_BITS-1:0] crat [NUM_ARCH];
    logic [PRN_BITS-1:0] fl   [NUM_PHYS];
    logic [PRN_BITS-1:0] head, tail, chead;
    logic [CNT_BITS-1:0] count;
    logic [NUM_PHYS-1:0] ready;

    logic [CNT_BITS-1:0] ndst, npop, npush, count_next;
    logic [CNT_BITS:0]   cnt_wide, cnt_chk;
    logic                dst_fit, fire;
    logic [PRN_BITS-1:0] alloc_ofs, push_ofs, ccount;
    logic [PRN_BITS-1:0] tail_upd, chead_upd;
    logic [PRN_BITS-1:0] rat_upd  [NUM_ARCH];
    logic [PRN_BITS-1:0] crat_upd [NUM_ARCH];
    logic [PRN_BITS-1:0] new_prn  [MAX_OPERANDS];
    logic [PRN_BITS-1:0] old_prn  [MAX_OPERANDS];
    logic [PRN_BITS-1:0] src_prn  [MAX_OPERANDS];
    logic                src_rdy  [MAX_OPERANDS];
    logic                hold_rdy [MAX_OPERANDS];
    logic [PRN_BITS-1:0] push_idx [MAX_OPERANDS];
    logic [NUM_PHYS-1:0] ready_upd;

    // Handshake and free-list sufficiency check.
    always_comb begin
        ndst = '0;
        for (int i = 0; i < MAX_OPERANDS; i++)
            if (in_dst_valid[i]) ndst = ndst + CNT_ONE;
        dst_fit  = (count >= ndst);
        in_ready = !flush && (!out_valid || out_ready) && dst_fit;
        fire     = in_valid && in_ready;
        npop     = fire ? ndst : '0;
    end

    // Destination allocation walks slots in order against a running RAT copy,
    // so a repeated ARN sees the lower slot's new PRN as its old mapping.
    always_comb begin
        rat_upd   = rat;
        alloc_ofs = '0;
        for (int i = 0; i < MAX_OPERANDS; i++) begin
            new_prn[i] = '0;
            old_prn[i] = '0;
            if (in_dst_valid[i]) begin
                new_prn[i] = fl[head + alloc_ofs];
                old_prn[i] = rat_upd[in_dst_arn[i]];
                rat_upd[in_dst_arn[i]] = new_prn[i];
                alloc_ofs = alloc_ofs + PTR_ONE;
            end
        end
    end

    // Sources read the pre-update RAT; ready includes same-cycle writebacks.
    always_comb begin
        for (int i = 0; i < MAX_OPERANDS; i++) begin
            src_prn[i]  = rat[in_src_arn[i]];
            src_rdy[i]  = ready[src_prn[i]];
            hold_rdy[i] = out_src_ready[i];
            for (int j = 0; j < MAX_OPERANDS; j++) begin
                if (wb_valid[j] && wb_prn[j] == src_prn[i])     src_rdy[i]  = 1'b1;
                if (wb_valid[j] && wb_prn[j] == out_src_prn[i]) hold_rdy[i] = 1'b1;
            end
        end
    end

    // Free-list pushes and committed-state updates.
    always_comb begin
        push_ofs = '0;
        npush    = '0;
        for (int j = 0; j < MAX_OPERANDS; j++) begin
            push_idx[j] = tail + push_ofs;
            if (free_valid[j]) begin
                push_ofs = push_ofs + PTR_ONE;
                npush    = npush + CNT_ONE;
            end
        end
        tail_upd = tail + push_ofs;

        crat_upd = crat;
        ccount   = '0;
        for (int j = 0; j < MAX_OPERANDS; j++) begin
            if (commit_valid[j]) begin
                crat_upd[commit_arn[j]] = commit_prn[j];
                ccount = ccount + PTR_ONE;
            end
        end
        chead_upd = chead + ccount;
    end

    // Wakeups land before allocation clears their own PRNs.
    always_comb begin
        ready_upd = ready;
        for (int j = 0; j < MAX_OPERANDS; j++)
            if (wb_valid[j]) ready_upd[wb_prn[j]] = 1'b1;
        if (fire)
            for (int i = 0; i < MAX_OPERANDS; i++)
                if (in_dst_valid[i]) ready_upd[new_prn[i]] = 1'b0;
    end

    // On flush the free list is exactly committed head .. tail.
    always_comb begin
        cnt_wide = {1'b0, count} - {1'b0, npop} + {1'b0, npush};
        if (flush) begin
            count_next = {1'b0, tail_upd - chead_upd};
            cnt_chk    = {1'b0, count_next};
        end else begin
            count_next = cnt_wide[CNT_BITS-1:0];
            cnt_chk    = cnt_wide;
        end
    end

    assign free_count = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < NUM_ARCH; a++) begin
                rat[a]  <= PRN_BITS'(a);
                crat[a] <= PRN_BITS'(a);
            end
            for (int p = 0; p < NUM_PHYS; p++)
                fl[p] <= PRN_BITS'((p + NUM_ARCH) % NUM_PHYS);
            head          <= '0;
            chead         <= '0;
            tail          <= PRN_BITS'(FREE_MAX);
            count         <= CNT_BITS'(FREE_MAX);
            ready         <= '1;
            out_valid     <= 1'b0;
            out_inst_id   <= '0;
            out_raw_instr <= '0;
            out_instr_pc  <= '0;
            out_fu_choice <= '0;
            for (int i = 0; i < MAX_OPERANDS; i++) begin
                out_src_valid[i] <= 1'b0;
                out_src_ready[i] <= 1'b0;
                out_src_prn[i]   <= '0;
                out_dst_valid[i] <= 1'b0;
                out_dst_prn[i]   <= '0;
                out_old_prn[i]   <= '0;
                out_dst_arn[i]   <= '0;
            end
        end else begin
            crat  <= crat_upd;
            chead <= chead_upd;
            tail  <= tail_upd;
            count <= count_next;
            ready <= ready_upd;
            for (int j = 0; j < MAX_OPERANDS; j++)
                if (free_valid[j]) fl[push_idx[j]] <= free_prn[j];

            if (flush) begin
                rat       <= crat_upd;
                head      <= chead_upd;
                out_valid <= 1'b0;
            end else if (fire) begin
                rat           <= rat_upd;
                head          <= head + PRN_BITS'(ndst);
                out_valid     <= 1'b1;
                out_inst_id   <= in_inst_id;
                out_raw_instr <= in_raw_instr;
                out_instr_pc  <= in_instr_pc;
                out_fu_choice <= in_fu_choice;
                for (int i = 0; i < MAX_OPERANDS; i++) begin
                    out_src_valid[i] <= in_src_valid[i];
                    out_src_ready[i] <= src_rdy[i];
                    out_src_prn[i]   <= src_prn[i];
                    out_dst_valid[i] <= in_dst_valid[i];
                    out_dst_prn[i]   <= new_prn[i];
                    out_old_prn[i]   <= old_prn[i];
                    out_dst_arn[i]   <= in_dst_arn[i];
                end
            end else begin
                if (out_ready) out_valid <= 1'b0;
                for (int i = 0; i < MAX_OPERANDS; i++)
                    out_src_ready[i] <= hold_rdy[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            assert (cnt_chk <= (CNT_BITS+1)'(FREE_MAX))
            else $error("rename_pipe_stage: free list occupancy out of range");
    end

`ifdef RENAME_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_freelist_cnt     <= '0;
            stall_backpressure_cnt <= '0;
        end else begin
            if (in_valid && !flush && !dst_fit && stall_freelist_cnt != '1)
                stall_freelist_cnt <= stall_freelist_cnt + 32'd1;
            if (in_valid && out_valid && !out_ready && stall_backpressure_cnt != '1)
                stall_backpressure_cnt <= stall_backpressure_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rename_pipe_stage.sv
module tb_rename_pipe_stage;

    localparam int MO = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [5:0]  in_inst_id;
    logic [31:0] in_raw_instr;
    logic [63:0] in_instr_pc;
    logic [1:0]  in_fu_choice;
    logic        in_src_valid [MO];
    logic [4:0]  in_src_arn   [MO];
    logic        in_dst_valid [MO];
    logic [4:0]  in_dst_arn   [MO];
    logic        out_valid, out_ready;
    logic [5:0]  out_inst_id;
    logic [31:0] out_raw_instr;
    logic [63:0] out_instr_pc;
    logic [1:0]  out_fu_choice;
    logic        out_src_valid [MO];
    logic        out_src_ready [MO];
    logic [5:0]  out_src_prn   [MO];
    logic        out_dst_valid [MO];
    logic [5:0]  out_dst_prn   [MO];
    logic [5:0]  out_old_prn   [MO];
    logic [4:0]  out_dst_arn   [MO];
    logic        wb_valid     [MO];
    logic [5:0]  wb_prn       [MO];
    logic        free_valid   [MO];
    logic [5:0]  free_prn     [MO];
    logic        commit_valid [MO];
    logic [4:0]  commit_arn   [MO];
    logic [5:0]  commit_prn   [MO];
    logic        flush;
    logic [6:0]  free_count;
`ifdef RENAME_STALL_CNT_EN
    logic [31:0] stall_freelist_cnt, stall_backpressure_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rename_pipe_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst_id(in_inst_id),
        .in_raw_instr(in_raw_instr), .in_instr_pc(in_instr_pc), .in_fu_choice(in_fu_choice),
        .in_src_valid(in_src_valid), .in_src_arn(in_src_arn),
        .in_dst_valid(in_dst_valid), .in_dst_arn(in_dst_arn),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst_id(out_inst_id),
        .out_raw_instr(out_raw_instr), .out_instr_pc(out_instr_pc), .out_fu_choice(out_fu_choice),
        .out_src_valid(out_src_valid), .out_src_ready(out_src_ready), .out_src_prn(out_src_prn),
        .out_dst_valid(out_dst_valid), .out_dst_prn(out_dst_prn), .out_old_prn(out_old_prn),
        .out_dst_arn(out_dst_arn),
        .wb_valid(wb_valid), .wb_prn(wb_prn),
        .free_valid(free_valid), .free_prn(free_prn),
        .commit_valid(commit_valid), .commit_arn(commit_arn), .commit_prn(commit_prn),
        .flush(flush), .free_count(free_count)
`ifdef RENAME_STALL_CNT_EN
        , .stall_freelist_cnt(stall_freelist_cnt)
        , .stall_backpressure_cnt(stall_backpressure_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_inst_id = '0; in_raw_instr = '0; in_instr_pc = '0; in_fu_choice = '0;
        flush = 0;
        for (int i = 0; i < MO; i++) begin
            in_src_valid[i] = 0; in_src_arn[i] = '0; in_dst_valid[i] = 0; in_dst_arn[i] = '0;
            wb_valid[i] = 0; wb_prn[i] = '0; free_valid[i] = 0; free_prn[i] = '0;
            commit_valid[i] = 0; commit_arn[i] = '0; commit_prn[i] = '0;
        end
    endtask

    task automatic set_instr(input logic [5:0] id,
                             input logic [2:0] sv, input logic [4:0] s0, input logic [4:0] s1,
                             input logic [2:0] dv, input logic [4:0] d0, input logic [4:0] d1,
                             input logic [4:0] d2);
        in_valid = 1; in_inst_id = id;
        in_src_valid[0] = sv[0]; in_src_valid[1] = sv[1]; in_src_valid[2] = sv[2];
        in_src_arn[0] = s0; in_src_arn[1] = s1; in_src_arn[2] = '0;
        in_dst_valid[0] = dv[0]; in_dst_valid[1] = dv[1]; in_dst_valid[2] = dv[2];
        in_dst_arn[0] = d0; in_dst_arn[1] = d1; in_dst_arn[2] = d2;
    endtask

    task automatic do_reset();
        idle();
        out_ready = 1;
        rst = 1;
        tick(); tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_cmp++; if (free_count !== 7'd32) begin n_err++; $display("FAIL reset_free_count: got %0d want 32", free_count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        n_cmp++; if (out_dst_prn[0] !== 6'd0 || out_src_ready[0] !== 1'b0 || out_instr_pc !== 64'd0)
            begin n_err++; $display("FAIL reset_out_regs: dst_prn %0d src_rdy %0b pc %0h want 0", out_dst_prn[0], out_src_ready[0], out_instr_pc); end
    endtask

    task automatic test_basic();
        do_reset();
        set_instr(6'd5, 3'b001, 5'd1, 5'd0, 3'b001, 5'd2, 5'd0, 5'd0);
        in_raw_instr = 32'hDEADBEEF; in_instr_pc = 64'h1000; in_fu_choice = 2'd2;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready: got %0b want 1", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_src_prn[0] !== 6'd1 || out_src_ready[0] !== 1'b1)
            begin n_err++; $display("FAIL basic_src: valid %0b prn %0d rdy %0b want 1/1/1", out_valid, out_src_prn[0], out_src_ready[0]); end
        n_cmp++; if (out_dst_prn[0] !== 6'd32 || out_old_prn[0] !== 6'd2 || out_dst_arn[0] !== 5'd2)
            begin n_err++; $display("FAIL basic_dst: prn %0d old %0d arn %0d want 32/2/2", out_dst_prn[0], out_old_prn[0], out_dst_arn[0]); end
        n_cmp++; if (out_inst_id !== 6'd5 || out_raw_instr !== 32'hDEADBEEF || out_instr_pc !== 64'h1000 || out_fu_choice !== 2'd2)
            begin n_err++; $display("FAIL basic_passthru: id %0d raw %0h pc %0h fu %0d", out_inst_id, out_raw_instr, out_instr_pc, out_fu_choice); end
        n_cmp++; if (free_count !== 7'd31) begin n_err++; $display("FAIL basic_free_count: got %0d want 31", free_count); end
        set_instr(6'd6, 3'b001, 5'd2, 5'd0, 3'b000, 5'd0, 5'd0, 5'd0);
        in_raw_instr = '0; in_instr_pc = '0; in_fu_choice = '0;
        tick();
        n_cmp++; if (out_src_prn[0] !== 6'd32 || out_src_ready[0] !== 1'b0 || out_dst_valid[0] !== 1'b0)
            begin n_err++; $display("FAIL basic_dep: prn %0d rdy %0b dstv %0b want 32/0/0", out_src_prn[0], out_src_ready[0], out_dst_valid[0]); end
    endtask

    // Continues from test_basic: output holds instruction 6 (src prn 32, not ready).
    task automatic test_wakeup_hold();
        out_ready = 0;
        set_instr(6'd7, 3'b001, 5'd2, 5'd0, 3'b000, 5'd0, 5'd0, 5'd0);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready: got %0b want 0", in_ready); end
        tick();
        n_cmp++; if (out_inst_id !== 6'd6 || out_src_ready[0] !== 1'b0)
            begin n_err++; $display("FAIL hold_stable: id %0d rdy %0b want 6/0", out_inst_id, out_src_ready[0]); end
        wb_valid[1] = 1; wb_prn[1] = 6'd32;
        tick();
        wb_valid[1] = 0;
        n_cmp++; if (out_src_ready[0] !== 1'b1 || out_inst_id !== 6'd6 || out_valid !== 1'b1)
            begin n_err++; $display("FAIL hold_wakeup: rdy %0b id %0d valid %0b want 1/6/1", out_src_ready[0], out_inst_id, out_valid); end
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready_after_wb: got %0b want 0", in_ready); end
        out_ready = 1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %0b want 1", in_ready); end
        tick();
        n_cmp++; if (out_inst_id !== 6'd7 || out_src_prn[0] !== 6'd32 || out_src_ready[0] !== 1'b1)
            begin n_err++; $display("FAIL table_wakeup: id %0d prn %0d rdy %0b want 7/32/1", out_inst_id, out_src_prn[0], out_src_ready[0]); end
        idle();
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_out_valid: got %0b want 0", out_valid); end
    endtask

    task automatic test_bypass();
        do_reset();
        set_instr(6'd1, 3'b000, 5'd0, 5'd0, 3'b001, 5'd3, 5'd0, 5'd0);
        tick();
        set_instr(6'd2, 3'b001, 5'd3, 5'd0, 3'b000, 5'd0, 5'd0, 5'd0);
        wb_valid[0] = 1; wb_prn[0] = 6'd32;
        tick();
        idle();
        n_cmp++; if (out_src_prn[0] !== 6'd32 || out_src_ready[0] !== 1'b1)
            begin n_err++; $display("FAIL wb_bypass: prn %0d rdy %0b want 32/1", out_src_prn[0], out_src_ready[0]); end
    endtask

    task automatic test_freelist_stall();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            set_instr(6'(k), 3'b000, 5'd0, 5'd0, 3'b111, 5'd10, 5'd11, 5'd12);
            tick();
        end
        set_instr(6'd10, 3'b000, 5'd0, 5'd0, 3'b001, 5'd13, 5'd0, 5'd0);
        tick();
        n_cmp++; if (free_count !== 7'd1) begin n_err++; $display("FAIL fl_count_one: got %0d want 1", free_count); end
        set_instr(6'd11, 3'b000, 5'd0, 5'd0, 3'b011, 5'd14, 5'd15, 5'd0);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fl_stall_in_ready: got %0b want 0", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b0 || free_count !== 7'd1)
            begin n_err++; $display("FAIL fl_stall_state: valid %0b count %0d want 0/1", out_valid, free_count); end
        free_valid[0] = 1; free_prn[0] = 6'd10;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fl_push_same_cycle: got %0b want 0", in_ready); end
        tick();
        free_valid[0] = 0;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || free_count !== 7'd2)
            begin n_err++; $display("FAIL fl_push_ready: rdy %0b count %0d want 1/2", in_ready, free_count); end
        tick();
        n_cmp++; if (out_dst_prn[0] !== 6'd63 || out_dst_prn[1] !== 6'd10 || out_old_prn[0] !== 6'd14 || out_old_prn[1] !== 6'd15)
            begin n_err++; $display("FAIL fl_wrap_alloc: prn %0d/%0d old %0d/%0d want 63/10/14/15", out_dst_prn[0], out_dst_prn[1], out_old_prn[0], out_old_prn[1]); end
        n_cmp++; if (free_count !== 7'd0) begin n_err++; $display("FAIL fl_empty_count: got %0d want 0", free_count); end
        set_instr(6'd12, 3'b000, 5'd0, 5'd0, 3'b001, 5'd16, 5'd0, 5'd0);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fl_empty_in_ready: got %0b want 0", in_ready); end
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        set_instr(6'd1, 3'b000, 5'd0, 5'd0, 3'b001, 5'd2, 5'd0, 5'd0);
        tick();
        tick();
        n_cmp++; if (out_dst_prn[0] !== 6'd33 || out_old_prn[0] !== 6'd32 || free_count !== 7'd30)
            begin n_err++; $display("FAIL flush_pre: prn %0d old %0d count %0d want 33/32/30", out_dst_prn[0], out_old_prn[0], free_count); end
        commit_valid[0] = 1; commit_arn[0] = 5'd2; commit_prn[0] = 6'd32;
        flush = 1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %0b want 0", in_ready); end
        tick();
        commit_valid[0] = 0; flush = 0;
        n_cmp++; if (out_valid !== 1'b0 || free_count !== 7'd31)
            begin n_err++; $display("FAIL flush_state: valid %0b count %0d want 0/31", out_valid, free_count); end
        set_instr(6'd3, 3'b001, 5'd2, 5'd0, 3'b001, 5'd7, 5'd0, 5'd0);
        tick();
        idle();
        n_cmp++; if (out_src_prn[0] !== 6'd32 || out_src_ready[0] !== 1'b0)
            begin n_err++; $display("FAIL flush_rat: prn %0d rdy %0b want 32/0", out_src_prn[0], out_src_ready[0]); end
        n_cmp++; if (out_dst_prn[0] !== 6'd33 || out_old_prn[0] !== 6'd7 || free_count !== 7'd30)
            begin n_err++; $display("FAIL flush_realloc: prn %0d old %0d count %0d want 33/7/30", out_dst_prn[0], out_old_prn[0], free_count); end
    endtask

    task automatic test_duplicate_dst();
        do_reset();
        set_instr(6'd9, 3'b001, 5'd5, 5'd0, 3'b011, 5'd5, 5'd5, 5'd0);
        tick();
        n_cmp++; if (out_src_prn[0] !== 6'd5) begin n_err++; $display("FAIL dup_src_pre: got %0d want 5", out_src_prn[0]); end
        n_cmp++; if (out_dst_prn[0] !== 6'd32 || out_old_prn[0] !== 6'd5 || out_dst_prn[1] !== 6'd33 || out_old_prn[1] !== 6'd32)
            begin n_err++; $display("FAIL dup_dst: %0d/%0d %0d/%0d want 32/5 33/32", out_dst_prn[0], out_old_prn[0], out_dst_prn[1], out_old_prn[1]); end
        set_instr(6'd10, 3'b001, 5'd5, 5'd0, 3'b000, 5'd0, 5'd0, 5'd0);
        tick();
        idle();
        n_cmp++; if (out_src_prn[0] !== 6'd33) begin n_err++; $display("FAIL dup_rat: got %0d want 33", out_src_prn[0]); end
    endtask

`ifdef RENAME_STALL_CNT_EN
    task automatic test_stall_cnt();
        do_reset();
        set_instr(6'd1, 3'b000, 5'd0, 5'd0, 3'b000, 5'd0, 5'd0, 5'd0);
        tick();
        out_ready = 0;
        for (int k = 0; k < 4; k++) tick();
        n_cmp++; if (stall_backpressure_cnt !== 32'd4) begin n_err++; $display("FAIL stall_bp_cnt: got %0d want 4", stall_backpressure_cnt); end
        n_cmp++; if (stall_freelist_cnt !== 32'd0) begin n_err++; $display("FAIL stall_fl_cnt: got %0d want 0", stall_freelist_cnt); end
        idle();
        out_ready = 1;
    endtask
`endif

    initial begin
        rst = 1; out_ready = 1;
        idle();
        test_reset();
        test_basic();
        test_wakeup_hold();
        test_bypass();
        test_freelist_stall();
        test_flush();
        test_duplicate_dst();
`ifdef RENAME_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
